// File: rtl/led_bank_if.sv
// Control and LED-output bundle between a board controller and the LED bank pattern generator.
// The master drives the run/mode/rate controls, and the slave returns the LED banks and the step tick.
interface led_bank_if #(
    parameter int N       = 32,
    parameter int PRESC_W = 24
);
    logic               en;
    logic [1:0]         mode;
    logic               mode_wr;
    logic               dir;
    logic [PRESC_W-1:0] presc_div;
    logic [N-1:0]       banks;
    logic               tick;

    modport master (
        output en, mode, mode_wr, dir, presc_div,
        input  banks, tick
    );

    modport slave (
        input  en, mode, mode_wr, dir, presc_div,
        output banks, tick
    );
endinterface

// File: rtl/led_bank_pattern_gen.sv
// LED bank pattern generator with four modes (binary count, Gray count, bouncing scan, PWM breathe).
// A runtime prescaler sets the step rate, and banks follows the pattern state one clock late.
module led_bank_pattern_gen #(
    parameter int BANKS   = 4,
    parameter int BANK_W  = 8,
    parameter int PRESC_W = 24,
    parameter int PWM_W   = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    led_bank_if.slave    bus
);
    localparam int N     = BANKS * BANK_W;
    localparam int POS_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [POS_W-1:0] POS_MAX = POS_W'(N - 1);

    typedef enum logic [1:0] {
        MODE_BIN     = 2'd0,
        MODE_GRAY    = 2'd1,
        MODE_SCAN    = 2'd2,
        MODE_BREATHE = 2'd3
    } mode_e;

    mode_e              mode_q;
    logic [PRESC_W-1:0] presc_cnt;
    logic [N-1:0]       cnt;
    logic [POS_W-1:0]   pos;
    logic               heading_up;
    logic [PWM_W-1:0]   duty;
    logic [PWM_W-1:0]   pwm_cnt;
    logic [N-1:0]       banks_q;
    logic               tick_q;
    logic [N-1:0]       pattern;
    logic               step;

    // A mode write wins over a step landing in the same cycle.
    assign step = bus.en && !bus.mode_wr && (presc_cnt >= bus.presc_div);

    // NOTE: every output of always_comb gets a default first so no latch is inferred.
    always_comb begin
        pattern = '0;
        unique case (mode_q)
            MODE_BIN:     pattern = cnt;
            MODE_GRAY:    pattern = cnt ^ (cnt >> 1);
            MODE_SCAN:    pattern[pos] = 1'b1;
            MODE_BREATHE: pattern = (pwm_cnt < duty) ? '1 : '0;
            default:      pattern = '0;
        endcase
    end

    // NOTE: state uses non-blocking assignments; the mode_wr clear sits last so it overrides.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q     <= MODE_BIN;
            presc_cnt  <= '0;
            cnt        <= '0;
            pos        <= '0;
            heading_up <= 1'b1;
            duty       <= '0;
            pwm_cnt    <= '0;
            banks_q    <= '0;
            tick_q     <= 1'b0;
        end else begin
            tick_q <= step;
            if (bus.en) begin
                banks_q   <= pattern;
                pwm_cnt   <= pwm_cnt + 1'b1;
                presc_cnt <= step ? '0 : presc_cnt + 1'b1;
            end
            if (step) begin
                unique case (mode_q)
                    MODE_BIN, MODE_GRAY: begin
                        cnt <= bus.dir ? cnt + 1'b1 : cnt - 1'b1;
                    end
                    MODE_SCAN: begin
                        if (heading_up) begin
                            if (pos == POS_MAX) begin
                                pos        <= pos - 1'b1;
                                heading_up <= 1'b0;
                            end else begin
                                pos <= pos + 1'b1;
                            end
                        end else begin
                            if (pos == '0) begin
                                pos        <= pos + 1'b1;
                                heading_up <= 1'b1;
                            end else begin
                                pos <= pos - 1'b1;
                            end
                        end
                    end
                    MODE_BREATHE: begin
                        if (heading_up) begin
                            if (duty == '1) begin
                                duty       <= duty - 1'b1;
                                heading_up <= 1'b0;
                            end else begin
                                duty <= duty + 1'b1;
                            end
                        end else begin
                            if (duty == '0) begin
                                duty       <= duty + 1'b1;
                                heading_up <= 1'b1;
                            end else begin
                                duty <= duty - 1'b1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
            if (bus.mode_wr) begin
                mode_q     <= mode_e'(bus.mode);
                presc_cnt  <= '0;
                cnt        <= '0;
                pos        <= '0;
                heading_up <= 1'b1;
                duty       <= '0;
                pwm_cnt    <= '0;
            end
        end
    end

    assign bus.banks = banks_q;
    assign bus.tick  = tick_q;
endmodule

// File: tb/tb_led_bank_pattern_gen.sv
// Self-checking bench for led_bank_pattern_gen: expected banks per step are queued by the stimulus
// and popped by a monitor one clock after each tick, alongside direct checks of timing and freeze.
module tb_led_bank_pattern_gen;
    localparam int N       = 32;
    localparam int PRESC_W = 24;

    logic clk = 1'b0;
    logic rst_n;
    int   n_vec = 0;
    int   n_err = 0;
    logic [N-1:0] sb_q[$];
    bit   sb_on = 1'b1;

    led_bank_if #(.N(N), .PRESC_W(PRESC_W)) bus ();

    led_bank_pattern_gen #(
        .BANKS(4), .BANK_W(8), .PRESC_W(PRESC_W), .PWM_W(8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // Monitor: banks is valid one clock after each tick.
    initial begin
        bit pend = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pend = 1'b0;
            end else begin
                if (pend && sb_on) begin
                    if (sb_q.size() == 0) begin
                        check("sb_unexpected_step", bus.banks, 32'hxxxx_xxxx);
                    end else begin
                        check("sb_banks", bus.banks, sb_q.pop_front());
                    end
                end
                pend = bus.tick;
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    task automatic write_mode(input logic [1:0] m);
        bus.mode    = m;
        bus.mode_wr = 1'b1;
        bus.en      = 1'b0;
        @(negedge clk);
        bus.mode_wr = 1'b0;
    endtask

    // n steps at full rate, then one more enabled cycle so banks shows the last state.
    task automatic do_steps(input int n);
        bus.en        = 1'b1;
        bus.presc_div = '0;
        repeat (n) @(negedge clk);
        bus.presc_div = '1;
        @(negedge clk);
        bus.en = 1'b0;
    endtask

    task automatic breathe_window(input string name, input int exp_lit);
        int lit = 0;
        int bad = 0;
        bus.en        = 1'b1;
        bus.presc_div = '1;
        repeat (4) @(negedge clk);
        repeat (256) begin
            @(negedge clk);
            if (bus.banks == '1) lit++;
            else if (bus.banks != '0) bad++;
        end
        bus.en = 1'b0;
        check(name, lit, exp_lit);
        check({name, "_uniform"}, bad, 0);
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.en        = 1'b0;
        bus.mode      = 2'd0;
        bus.mode_wr   = 1'b0;
        bus.dir       = 1'b1;
        bus.presc_div = '0;
        #23;
        check("reset_banks", bus.banks, 32'h0);
        check("reset_tick", bus.tick, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Binary count up, a step every 4th clock.
        write_mode(2'd0);
        bus.dir       = 1'b1;
        bus.presc_div = 24'd3;
        bus.en        = 1'b1;
        for (int k = 1; k <= 4; k++) sb_q.push_back(N'(k));
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            check($sformatf("bin_tick_%0d", i), bus.tick, (i % 4) == 0);
        end
        bus.presc_div = '1;
        @(negedge clk);
        bus.en = 1'b0;
        check("bin_after_4_ticks", bus.banks, 32'h0000_0004);

        // Binary count down from zero wraps, then freeze.
        write_mode(2'd0);
        bus.dir = 1'b0;
        sb_q.push_back(32'hFFFF_FFFF);
        do_steps(1);
        check("bin_down_wrap", bus.banks, 32'hFFFF_FFFF);
        bus.presc_div = '0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("freeze_banks", bus.banks, 32'hFFFF_FFFF);
            check("freeze_tick", bus.tick, 1'b0);
        end

        // Gray count.
        write_mode(2'd1);
        bus.dir = 1'b1;
        sb_q.push_back(32'h1);
        sb_q.push_back(32'h3);
        sb_q.push_back(32'h2);
        sb_q.push_back(32'h6);
        do_steps(4);
        check("gray_final", bus.banks, 32'h0000_0006);

        // Bouncing scan, dir ignored.
        write_mode(2'd2);
        bus.dir = 1'b0;
        for (int k = 1; k <= 63; k++) begin
            int p;
            logic [N-1:0] one;
            p   = (k <= 31) ? k : ((k <= 62) ? 62 - k : 1);
            one = N'(1);
            sb_q.push_back(one << p);
        end
        do_steps(63);
        check("scan_final", bus.banks, 32'h0000_0002);
        check("sb_drained_scan", sb_q.size(), 0);

        // Breathe: duty observed as lit cycles per 256-clock window.
        sb_on = 1'b0;
        write_mode(2'd3);
        breathe_window("breathe_duty0", 0);
        do_steps(64);
        breathe_window("breathe_duty64", 64);
        do_steps(191);
        breathe_window("breathe_duty255", 255);
        do_steps(1);
        breathe_window("breathe_duty254", 254);

        // mode_wr on a step cycle suppresses the tick and restarts in the new mode.
        write_mode(2'd0);
        bus.dir       = 1'b1;
        bus.presc_div = '0;
        bus.en        = 1'b1;
        repeat (2) @(negedge clk);
        bus.mode    = 2'd2;
        bus.mode_wr = 1'b1;
        @(negedge clk);
        bus.mode_wr = 1'b0;
        check("modewr_tick_suppressed", bus.tick, 1'b0);
        @(negedge clk);
        check("modewr_initial_pattern", bus.banks, 32'h0000_0001);
        check("modewr_first_tick", bus.tick, 1'b1);
        @(negedge clk);
        check("modewr_second_pattern", bus.banks, 32'h0000_0002);

        // Asynchronous reset with no clock edge.
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_banks", bus.banks, 32'h0);
        check("async_reset_tick", bus.tick, 1'b0);
        bus.en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("sb_drained_end", sb_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
